// File: rtl/usb_fs_pkg.sv
// Shared USB full-speed definitions: PID codes and the rx demux state encoding.
package usb_fs_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_SOF   = 4'b0101;

    typedef enum logic [1:0] {
        DEMUX_IDLE,
        DEMUX_OUT_WAIT_DATA,
        DEMUX_OUT_PID_CHECK,
        DEMUX_OUT_DATA
    } demux_state_t;

    function automatic logic pid_is_data(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_fs_timeout_ctr.sv
// Free-running wait counter; expire is high during the final counted cycle of the window.
module usb_fs_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/usb_fs_rx_demux.sv
// Routes decoded rx packets to the IN and OUT protocol engines: address filtering,
// OUT/SETUP-to-DATA binding with timeout, and host ACK delivery for an outstanding IN.
module usb_fs_rx_demux
    import usb_fs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] dev_addr,
    input  logic       rx_pkt_start,
    input  logic       rx_pkt_end,
    input  logic       rx_pkt_valid,
    input  logic [3:0] rx_pid,
    input  logic [6:0] rx_addr,
    input  logic [3:0] rx_endp,
    input  logic       rx_data_put,
    input  logic [7:0] rx_data,
    output logic       in_token_received,
    output logic       in_ack_received,
    output logic [3:0] in_endp,
    output logic       out_token_received,
    output logic       out_setup_received,
    output logic [3:0] out_endp,
    output logic       out_pkt_start,
    output logic [3:0] out_pid,
    output logic       out_data_put,
    output logic [7:0] out_data,
    output logic       out_pkt_end,
    output logic       out_pkt_valid,
    output logic       out_timeout
);

    demux_state_t state, state_next;
    logic         in_pending, in_pending_next;

    logic       in_token_next, in_ack_next, out_token_next, out_setup_next;
    logic       out_pkt_start_next, out_data_put_next, out_pkt_end_next;
    logic       out_pkt_valid_next, out_timeout_next;
    logic [3:0] in_endp_next, out_endp_next, out_pid_next;
    logic [7:0] out_data_next;

    logic pkt_ok, addr_hit, out_match, in_match, ack_end;
    logic tmr_clear, tmr_enable, tmr_expire;

    assign pkt_ok    = rx_pkt_end && rx_pkt_valid;
    assign addr_hit  = (rx_addr == dev_addr);
    assign out_match = pkt_ok && addr_hit && ((rx_pid == PID_OUT) || (rx_pid == PID_SETUP));
    assign in_match  = pkt_ok && addr_hit && (rx_pid == PID_IN);
    assign ack_end   = pkt_ok && (rx_pid == PID_ACK);

    assign tmr_clear  = (state == DEMUX_IDLE) && out_match;
    assign tmr_enable = (state == DEMUX_OUT_WAIT_DATA);

    usb_fs_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= DEMUX_IDLE;
            in_pending         <= 1'b0;
            in_token_received  <= 1'b0;
            in_ack_received    <= 1'b0;
            in_endp            <= '0;
            out_token_received <= 1'b0;
            out_setup_received <= 1'b0;
            out_endp           <= '0;
            out_pkt_start      <= 1'b0;
            out_pid            <= '0;
            out_data_put       <= 1'b0;
            out_data           <= '0;
            out_pkt_end        <= 1'b0;
            out_pkt_valid      <= 1'b0;
            out_timeout        <= 1'b0;
        end else begin
            state              <= state_next;
            in_pending         <= in_pending_next;
            in_token_received  <= in_token_next;
            in_ack_received    <= in_ack_next;
            in_endp            <= in_endp_next;
            out_token_received <= out_token_next;
            out_setup_received <= out_setup_next;
            out_endp           <= out_endp_next;
            out_pkt_start      <= out_pkt_start_next;
            out_pid            <= out_pid_next;
            out_data_put       <= out_data_put_next;
            out_data           <= out_data_next;
            out_pkt_end        <= out_pkt_end_next;
            out_pkt_valid      <= out_pkt_valid_next;
            out_timeout        <= out_timeout_next;
        end
    end

    // A packet start while waiting wins over an expiry in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            DEMUX_IDLE: begin
                if (out_match) state_next = DEMUX_OUT_WAIT_DATA;
            end
            DEMUX_OUT_WAIT_DATA: begin
                if (rx_pkt_start)    state_next = DEMUX_OUT_PID_CHECK;
                else if (tmr_expire) state_next = DEMUX_IDLE;
            end
            DEMUX_OUT_PID_CHECK: begin
                state_next = pid_is_data(rx_pid) ? DEMUX_OUT_DATA : DEMUX_IDLE;
            end
            DEMUX_OUT_DATA: begin
                if (rx_pkt_end) state_next = DEMUX_IDLE;
            end
            default: state_next = DEMUX_IDLE;
        endcase
    end

    always_comb begin
        in_pending_next    = in_pending;
        in_token_next      = 1'b0;
        in_ack_next        = 1'b0;
        in_endp_next       = in_endp;
        out_token_next     = 1'b0;
        out_setup_next     = 1'b0;
        out_endp_next      = out_endp;
        out_pkt_start_next = 1'b0;
        out_pid_next       = out_pid;
        out_data_put_next  = 1'b0;
        out_data_next      = out_data;
        out_pkt_end_next   = 1'b0;
        out_pkt_valid_next = 1'b0;
        out_timeout_next   = 1'b0;
        case (state)
            DEMUX_IDLE: begin
                if (out_match) begin
                    out_token_next  = (rx_pid == PID_OUT);
                    out_setup_next  = (rx_pid == PID_SETUP);
                    out_endp_next   = rx_endp;
                    in_pending_next = 1'b0;
                end else if (in_match) begin
                    in_token_next   = 1'b1;
                    in_endp_next    = rx_endp;
                    in_pending_next = 1'b1;
                end else if (ack_end) begin
                    in_ack_next     = in_pending;
                    in_pending_next = 1'b0;
                end else if (pkt_ok) begin
                    in_pending_next = 1'b0;
                end
            end
            DEMUX_OUT_WAIT_DATA: begin
                out_timeout_next = tmr_expire && !rx_pkt_start;
            end
            DEMUX_OUT_PID_CHECK: begin
                if (pid_is_data(rx_pid)) begin
                    out_pkt_start_next = 1'b1;
                    out_pid_next       = rx_pid;
                end
            end
            DEMUX_OUT_DATA: begin
                out_data_put_next = rx_data_put;
                if (rx_data_put) out_data_next = rx_data;
                if (rx_pkt_end) begin
                    out_pkt_end_next   = 1'b1;
                    out_pkt_valid_next = rx_pkt_valid;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/usb_fs_rx_demux.md
Name: usb_fs_rx_demux

Overview:
Receive-side counterpart to the transmit mux that merges IN/OUT protocol engine requests onto the shared tx module. Takes decoded packet events from the shared USB full-speed rx module and routes them to the IN and OUT protocol engines. Filters tokens on device address and binds each OUT/SETUP token to its following DATA0/DATA1 packet. Tracks an outstanding IN transaction so that host ACKs reach the IN engine.

Parameters:
TIMEOUT_CYCLES, 256, clocks to wait in OUT_WAIT_DATA for the data packet before abandoning the transaction (must be ≥2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dev_addr  in  7  current device address
rx_pkt_start  in  1  1-cycle pulse, rx detected packet start
rx_pkt_end  in  1  1-cycle pulse, packet finished
rx_pkt_valid  in  1  CRC/PID check result, qualified by rx_pkt_end
rx_pid  in  4  packet PID; valid from the cycle after rx_pkt_start until the next rx_pkt_start
rx_addr  in  7  token address; valid on rx_pkt_end
rx_endp  in  4  token endpoint; valid on rx_pkt_end
rx_data_put  in  1  data byte strobe
rx_data  in  8  data byte
in_token_received  out  1  pulse: IN token addressed to this device
in_ack_received  out  1  pulse: ACK for the outstanding IN transaction
in_endp  out  4  endpoint of the last accepted IN token
out_token_received  out  1  pulse: OUT token addressed to this device
out_setup_received  out  1  pulse: SETUP token addressed to this device
out_endp  out  4  endpoint of the last accepted OUT/SETUP token
out_pkt_start  out  1  pulse: bound DATA packet begins
out_pid  out  4  PID of the bound DATA packet (DATA0/DATA1)
out_data_put  out  1  forwarded byte strobe
out_data  out  8  forwarded byte
out_pkt_end  out  1  pulse: bound DATA packet ended
out_pkt_valid  out  1  rx_pkt_valid, qualified by out_pkt_end
out_timeout  out  1  pulse: data packet never arrived

Behaviour:
- All outputs are registered. Reset: all pulses 0, in_endp/out_endp/out_pid/out_data 0, state IDLE, in_pending 0, counter 0.
- Token match: rx_pkt_end & rx_pkt_valid & rx_pid ∈ {OUT, IN, SETUP} & rx_addr==dev_addr. The matching token pulse asserts the next cycle, and the endpoint register updates in that same cycle.
- States:
  - IDLE.
  - OUT_WAIT_DATA.
  - OUT_PID_CHECK.
  - OUT_DATA.
- IDLE:
  - OUT or SETUP match → OUT_WAIT_DATA; counter cleared; in_pending cleared.
  - IN match → in_pending set; stays in IDLE.
  - Valid ACK with in_pending=1 → in_ack_received pulse; in_pending cleared.
  - Any other valid non-ACK packet end clears in_pending.
  - DATA packets are ignored.
- OUT_WAIT_DATA:
  - Counter increments each cycle.
  - rx_pkt_start → OUT_PID_CHECK. This has priority over the timeout in the same cycle.
  - Counter reaching TIMEOUT_CYCLES-1 → out_timeout pulse, then IDLE.
- OUT_PID_CHECK (1 cycle):
  - rx_pid ∈ {DATA0, DATA1} → out_pkt_start pulse, out_pid latched, → OUT_DATA.
  - Otherwise → IDLE. The packet is then evaluated as a normal token at its rx_pkt_end; a new matching token restarts routing.
- OUT_DATA:
  - Each rx_data_put is forwarded with 1-cycle latency.
  - On rx_pkt_end: out_pkt_end pulse with out_pkt_valid=rx_pkt_valid, then IDLE. An invalid packet is still terminated, with out_pkt_valid=0.
- Invalid tokens (rx_pkt_valid=0) are ignored in all states.
- Address mismatch produces no pulse and no state change, except that in_pending is cleared by any valid non-ACK token.
- Reset asserted mid-packet returns to IDLE immediately. Remaining bytes and the packet end of that packet are not forwarded.
- dev_addr is sampled only at token end.

Decomposition:
- Package usb_fs_pkg holds the PID constants: OUT=4'b0001, IN=4'b1001, SETUP=4'b1101, DATA0=4'b0011, DATA1=4'b1011, ACK=4'b0010, NAK=4'b1010, STALL=4'b1110, SOF=4'b0101.
- The package also holds the demux state enum.
- Timeout counter sub-module: usb_fs_timeout_ctr (clear, enable, expire pulse, width $clog2(TIMEOUT_CYCLES)).

Test Plan:
1. dev_addr=7'h05. OUT token addr 5, endp 2, valid; then DATA1 with bytes 8'hA1, 8'hB2, valid.
   → out_token_received=1, out_endp=2, out_pkt_start=1, out_pid=4'b1011; out_data 8'hA1, 8'hB2 each 1 cycle after its put; out_pkt_end with out_pkt_valid=1.
2. IN token addr 5, endp 1; then valid ACK.
   → in_token_received=1, in_endp=1, in_ack_received=1 once. A second ACK produces no pulse.
3. SETUP token addr 6 while dev_addr=5.
   → no output pulses; state stays IDLE; a following DATA0 is not forwarded.
4. OUT token match, then no packet for 256 cycles.
   → out_timeout pulses exactly 256 cycles after the token pulse; a following DATA0 is ignored.
5. OUT match; DATA0 with rx_pkt_valid=0 at end.
   → out_pkt_end=1 with out_pkt_valid=0; back to IDLE.
6. Reset asserted after the 1st data byte of a bound DATA0.
   → no further out_data_put and no out_pkt_end; all outputs 0 the cycle after reset.
